// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC selection and IF/ID pipeline register.
// Decode resolves redirects; the instruction fetched alongside a redirect (delay slot) is always kept.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       pc_control,
   input  logic [31:0]      rs_data_d,
   input  logic [31:0]      instr_f,
   output logic [31:0]      pc_f,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc8_d,
   output logic             valid_d,
   output logic             addr_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic [1:0] CTL_SEQ    = 2'd0;
   localparam logic [1:0] CTL_BRANCH = 2'd1;
   localparam logic [1:0] CTL_REG    = 2'd2;
   localparam logic [1:0] CTL_JUMP   = 2'd3;

   logic [31:0]      pc_f_reg;
   logic [31:0]      instr_d_reg;
   logic [31:0]      pc_d_reg;
   logic             valid_d_reg;
   logic             addr_err_reg;
   logic [CNT_W-1:0] redirect_cnt_reg;

   logic [1:0]       eff_ctl;
   logic [31:0]      br_offset;
   logic [31:0]      npc_next;
   logic             misaligned;

   // A bubble in decode carries no real instruction, so it can never redirect.
   assign eff_ctl    = valid_d_reg ? pc_control : CTL_SEQ;
   assign br_offset  = {{14{instr_d_reg[15]}}, instr_d_reg[15:0], 2'b00};
   assign misaligned = (eff_ctl == CTL_REG) && (rs_data_d[1:0] != 2'b00);

   always_comb begin
      npc_next = pc_f_reg + 32'd4;
      case (eff_ctl)
         CTL_SEQ:    npc_next = pc_f_reg + 32'd4;
         CTL_BRANCH: npc_next = pc_d_reg + 32'd4 + br_offset;
         CTL_REG:    npc_next = {rs_data_d[31:2], 2'b00};
         CTL_JUMP:   npc_next = {pc_d_reg[31:28], instr_d_reg[25:0], 2'b00};
         default:    npc_next = pc_f_reg + 32'd4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_reg         <= RESET_PC;
         instr_d_reg      <= 32'h0;
         pc_d_reg         <= 32'h0;
         valid_d_reg      <= 1'b0;
         addr_err_reg     <= 1'b0;
         redirect_cnt_reg <= '0;
      end else if (!stall) begin
         pc_f_reg    <= npc_next;
         instr_d_reg <= instr_f;
         pc_d_reg    <= pc_f_reg;
         valid_d_reg <= 1'b1;
         if (eff_ctl != CTL_SEQ)
            redirect_cnt_reg <= redirect_cnt_reg + CNT_W'(1);
         if (misaligned)
            addr_err_reg <= 1'b1;
      end
   end

   assign pc_f         = pc_f_reg;
   assign instr_d      = instr_d_reg;
   assign pc_d         = pc_d_reg;
   assign pc8_d        = pc_d_reg + 32'd8;
   assign valid_d      = valid_d_reg;
   assign addr_err     = addr_err_reg;
   assign redirect_cnt = redirect_cnt_reg;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage half of the decode-stage branch/jump resolution path.
- Consumes the 2-bit PC-control code that decode produces: 0 = sequential, 1 = beq taken, 2 = jr/jalr, 3 = j/jal.
- Owns the PC register, the next-PC mux and the IF/ID pipeline register, and issues the instruction-memory fetch address.
- Implements the MIPS single delay slot: the instruction fetched in the same cycle decode resolves a redirect is always kept.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- CNT_W, 32, width of the accepted-redirect counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit freeze of the PC and IF/ID registers.
- pc_control  input  2  decode redirect code (0 seq, 1 branch, 2 register, 3 jump).
- rs_data_d  input  32  forwarded rs value in decode, used as the jr/jalr target.
- instr_f  input  32  instruction-memory read data for pc_f.
- pc_f  output  32  fetch address to instruction memory.
- instr_d  output  32  IF/ID instruction register.
- pc_d  output  32  IF/ID PC register.
- pc8_d  output  32  pc_d + 8, the link value for jal/jalr.
- valid_d  output  1  IF/ID holds a fetched instruction.
- addr_err  output  1  sticky flag: misaligned register-jump target was seen.
- redirect_cnt  output  CNT_W  number of accepted redirects.

Behaviour:
- Reset values:
  - pc_f = RESET_PC.
  - instr_d = 32'h0 (nop).
  - pc_d = 0.
  - valid_d = 0.
  - addr_err = 0.
  - redirect_cnt = 0.
- Reset takes priority over stall and over every other input.
- Effective control: eff = valid_d ? pc_control : 0. A bubble in decode never redirects.
- npc, combinational, all arithmetic modulo 2^32:
  - eff 0: pc_f + 4.
  - eff 1: pc_d + 4 + (sign_ext(instr_d[15:0]) << 2).
  - eff 2: {rs_data_d[31:2], 2'b00}.
  - eff 3: {pc_d[31:28], instr_d[25:0], 2'b00}.
- Advance (stall = 0), on the clock edge:
  - pc_f <= npc.
  - instr_d <= instr_f.
  - pc_d <= pc_f.
  - valid_d <= 1.
- Latency: a redirect resolved in cycle N makes pc_f equal the target in cycle N+1.
- The delay-slot instruction (at pc_d + 4) enters IF/ID in the same edge and is never squashed.
- Hold (stall = 1):
  - pc_f, instr_d, pc_d and valid_d hold their values.
  - pc_control is ignored.
  - The redirect counter does not increment.
  - addr_err does not change.
  - No redirect is latched: decode re-presents the same instruction and recomputes the redirect after the stall ends.
- pc8_d = pc_d + 8, combinational, wraps at 2^32.
- addr_err:
  - Set on an advancing edge when eff = 2 and rs_data_d[1:0] != 0.
  - Cleared only by reset.
  - The target is still forced word-aligned.
- redirect_cnt: increments by 1 on every advancing edge with eff != 0; wraps modulo 2^CNT_W.
- Sequential wrap: pc_f = 32'hFFFF_FFFC advancing with eff 0 gives pc_f = 0.
- Back-to-back redirects (a jump in the delay slot) are legal. Each is evaluated independently from its own pc_d/instr_d.
- No internal state machine beyond the reset and valid qualification. The two effective states are BUBBLE (valid_d = 0, after reset) and RUN (after the first advancing edge).

Test Plan:
1. Reset, then 3 un-stalled cycles with eff 0:
   - pc_f = 3000, 3004, 3008, 300C.
   - valid_d goes to 1 after the first edge.
   - pc_d = 3000 in the second cycle.
2. beq taken:
   - Setup: pc_d = 3008, instr_d[15:0] = 16'hFFFE, pc_control = 1.
   - Next pc_f = 3004.
   - pc_d becomes 300C (the delay slot).
   - redirect_cnt increments by 1.
3. j/jal:
   - Setup: pc_d = 3010, instr_d = 0C00_0C20, pc_control = 3.
   - Next pc_f = 0000_3080.
   - pc8_d = 3018 in the jal cycle.
4. jr with rs_data_d = 0000_3101, pc_control = 2:
   - pc_f = 0000_3100.
   - addr_err = 1 and stays 1 afterwards.
   - A later reset clears it.
5. stall = 1 for 3 cycles with pc_control = 3 held:
   - pc_f, pc_d, instr_d and redirect_cnt are unchanged.
   - On release, exactly one redirect is taken and the count increments once.
6. Boundary cases:
   - pc_f = FFFF_FFFC, eff 0: pc_f = 0.
   - Assert reset together with stall = 1: pc_f = RESET_PC and valid_d = 0.
   - pc_control = 1 while valid_d = 0: ignored, pc_f + 4 is taken.
